cache_l2_l1_responder: RTL and testbench
========================================

Name: cache_l2_l1_responder

Overview:
- L2-side responder for the L1<->L2 block link.
- Accepts one block request at a time from the L1 link (arbitrated L1I/L1D traffic) and looks the block up in the L2 data array.
- On a miss, hands off to the L2 miss/fill engine and waits for it to finish.
- For a read it streams BLOCK_WORDS words back to L1 with a valid/ack handshake; for a write it accepts BLOCK_WORDS words into the array.

Parameters:
- BLOCK_WORDS, 4, words per cache block; power of 2, >=2.
- ADDR_W, 24, word-address width.
- DATA_W, 32, data word width.

Ports:
- clock_i  in  1  system clock; all logic on posedge.
- reset_i  in  1  asynchronous, active-high reset.
- l1_req_i  in  1  L1 block request strobe.
- l1_rw_i  in  1  request type: 0=read block, 1=write block.
- l1_add_i  in  ADDR_W  request word address.
- l1_data_i  in  DATA_W  write word from L1.
- l1_write_i  in  1  L1 presents a write word.
- l1_read_ack_i  in  1  L1 consumed the current read word.
- l1_ready_o  out  1  responder idle, can accept a request.
- l1_valid_o  out  1  l1_data_o holds a valid read word.
- l1_data_o  out  DATA_W  read word to L1.
- l1_write_ready_o  out  1  responder can take a write word.
- l1_done_o  out  1  one-cycle pulse: block transfer complete.
- arr_add_o  out  ADDR_W  L2 array word address.
- arr_re_o  out  1  array read enable; data returns on arr_data_i the next cycle.
- arr_we_o  out  1  array write enable.
- arr_data_o  out  DATA_W  array write data.
- arr_data_i  in  DATA_W  array read data.
- arr_hit_i  in  1  tag hit for arr_add_o; combinational, sampled in LOOKUP.
- miss_req_o  out  1  level request to the fill engine; held until miss_done_i.
- miss_done_i  in  1  fill complete pulse.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset values: all outputs 0, except l1_ready_o, which goes to 1 on the first clock after reset deasserts. Reset mid-transfer aborts the transfer: FSM to IDLE, word counter to 0, miss_req_o dropped, no l1_done_o pulse.
- FSM states: IDLE, LOOKUP, MISS, RD_ISSUE, RD_WAIT, RD_HOLD, WR_ACCEPT, DONE.
- IDLE:
  - l1_ready_o=1.
  - On l1_req_i, latch the block base = l1_add_i with the low log2(BLOCK_WORDS) bits cleared, latch rw, set counter=0, go to LOOKUP.
  - l1_req_i in any other state is ignored.
- LOOKUP:
  - arr_add_o=base.
  - arr_hit_i=1: go to RD_ISSUE if rw=0, WR_ACCEPT if rw=1.
  - arr_hit_i=0: go to MISS.
- MISS:
  - miss_req_o=1.
  - On miss_done_i, return to LOOKUP; the second lookup must hit.
  - A second miss sets err_o and re-enters MISS.
- RD_ISSUE: arr_re_o=1, arr_add_o=base+counter, go to RD_WAIT.
- RD_WAIT: register arr_data_i into l1_data_o, set l1_valid_o, go to RD_HOLD.
- RD_HOLD:
  - l1_valid_o and l1_data_o are held stable until l1_read_ack_i.
  - On ack: drop valid the next cycle and increment counter.
  - If counter was BLOCK_WORDS-1, go to DONE; otherwise go to RD_ISSUE.
  - Minimum 3 cycles per word. First valid appears 4 cycles after req acceptance on a hit.
- WR_ACCEPT:
  - l1_write_ready_o=1.
  - Each cycle with l1_write_i=1: arr_we_o=1, arr_add_o=base+counter, arr_data_o=l1_data_i, counter+1.
  - After word BLOCK_WORDS-1, go to DONE. Back-to-back words at 1 per cycle are allowed.
- DONE: l1_done_o=1 for one cycle, then IDLE.
- Counter width is log2(BLOCK_WORDS). The address add never carries out of the block (wraps within the block).
- Protocol errors (err_o set, event otherwise ignored):
  - l1_read_ack_i while l1_valid_o=0.
  - l1_write_i while l1_write_ready_o=0.
- err_o clears only on reset.

Optional Feature:
- CACHE_L2_RESPONDER_PERF_EN:
  - When defined, adds outputs perf_hit_o[31:0] and perf_miss_o[31:0].
  - perf_hit_o increments on a first-pass LOOKUP hit; perf_miss_o increments on entering MISS from LOOKUP.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Shared package l2_link_pkg holds:
  - the FSM state enum;
  - RW_READ=0 / RW_WRITE=1 constants;
  - BLOCK_WORDS default.
- Sub-module l2_perf_counter: saturating 32-bit counter, instantiated twice under the macro.

Test Plan:
- Read hit: req rw=0 add=0x000013, arr_hit_i=1, array words 0x10..0x13 = A0..A3, ack 1 cycle after each valid → arr_add 0x10,0x11,0x12,0x13; l1_data_o A0..A3; first valid 4 cycles after req; single l1_done_o pulse.
- Write miss: req rw=1 add=0x000200, hit=0, miss_done_i after 20 cycles, then hit=1; write D0..D3 back-to-back → miss_req_o high 20 cycles; arr_we_o on 4 consecutive cycles at 0x200..0x203 with D0..D3; l1_done_o once.
- Read with ack stalled 10 cycles on word 2 → l1_valid_o and l1_data_o stable for all 10 cycles; no extra arr_re_o.
- Protocol errors: ack while valid=0 in IDLE → err_o=1 and stays 1; a new request still completes normally.
- Reset mid-transfer: assert reset_i during RD_HOLD of word 1 → all outputs 0 immediately; after release l1_ready_o=1; no l1_done_o pulse.
- With CACHE_L2_RESPONDER_PERF_EN defined: 3 hits and 2 misses → perf_hit_o=3, perf_miss_o=2. The two miss requests are also counted as hits on their refill lookups, so perf_hit_o must read 3, not 5: second-pass lookups are not counted.

Source files
------------

// File: rtl/l2_link_pkg.sv
// Shared types and constants for the L2 side of the L1<->L2 block link.
// FSM state encoding, request-type codes and default sizes.
package l2_link_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MISS,
      RD_ISSUE,
      RD_WAIT,
      RD_HOLD,
      WR_ACCEPT,
      DONE
   } l2State_t;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   localparam int DEF_BLOCK_WORDS = 4;
   localparam int PERF_W = 32;

endpackage

// File: rtl/l2_perf_counter.sv
// Saturating event counter for L2 responder statistics.
// Holds at all-ones instead of wrapping.
module l2_perf_counter
   import l2_link_pkg::*;
(
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              inc_i,
   output logic [PERF_W-1:0] count_o
);

   // count events, stick at the maximum value
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         count_o <= '0;
      end else if (inc_i && (count_o != '1)) begin
         count_o <= count_o + PERF_W'(1);
      end
   end

endmodule

// File: rtl/cache_l2_l1_responder.sv
// L2 responder for L1 block reads/writes, with miss hand-off to the fill engine.
// Optional hit/miss statistics when CACHE_L2_RESPONDER_PERF_EN is defined.
module cache_l2_l1_responder
   import l2_link_pkg::*;
#(
   parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
   parameter int ADDR_W      = 24,
   parameter int DATA_W      = 32
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              l1_req_i,
   input  logic              l1_rw_i,
   input  logic [ADDR_W-1:0] l1_add_i,
   input  logic [DATA_W-1:0] l1_data_i,
   input  logic              l1_write_i,
   input  logic              l1_read_ack_i,
   output logic              l1_ready_o,
   output logic              l1_valid_o,
   output logic [DATA_W-1:0] l1_data_o,
   output logic              l1_write_ready_o,
   output logic              l1_done_o,
   output logic [ADDR_W-1:0] arr_add_o,
   output logic              arr_re_o,
   output logic              arr_we_o,
   output logic [DATA_W-1:0] arr_data_o,
   input  logic [DATA_W-1:0] arr_data_i,
   input  logic              arr_hit_i,
   output logic              miss_req_o,
   input  logic              miss_done_i,
   output logic              err_o
`ifdef CACHE_L2_RESPONDER_PERF_EN
   ,
   output logic [31:0]       perf_hit_o,
   output logic [31:0]       perf_miss_o
`endif
);

   localparam int CW = $clog2(BLOCK_WORDS);

   l2State_t          state;
   l2State_t          nextState;
   logic [ADDR_W-1:0] baseQ;
   logic              rwQ;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cntNext;
   logic              refillQ;
   logic              armedQ;
   logic              validQ;
   logic [DATA_W-1:0] dataQ;
   logic              errQ;
   logic              accept;
   logic              loadData;
   logic              dropValid;
   logic              errSet;
   logic [ADDR_W-1:0] wordAdd;

   assign l1_valid_o = validQ;
   assign l1_data_o  = dataQ;
   assign err_o      = errQ;
   assign wordAdd    = baseQ | ADDR_W'(cnt);

   // next-state decode and combinational link/array outputs
   always_comb begin
      nextState        = state;
      cntNext          = cnt;
      accept           = 1'b0;
      loadData         = 1'b0;
      dropValid        = 1'b0;
      errSet           = 1'b0;
      l1_ready_o       = 1'b0;
      l1_write_ready_o = 1'b0;
      l1_done_o        = 1'b0;
      arr_add_o        = '0;
      arr_re_o         = 1'b0;
      arr_we_o         = 1'b0;
      arr_data_o       = '0;
      miss_req_o       = 1'b0;
      unique case (1'b1)
         (state == IDLE): begin
            l1_ready_o = armedQ;
            if (armedQ && l1_req_i) begin
               accept    = 1'b1;
               cntNext   = '0;
               nextState = LOOKUP;
            end
         end
         (state == LOOKUP): begin
            arr_add_o = baseQ;
            if (arr_hit_i) begin
               nextState = (rwQ == RW_WRITE) ? WR_ACCEPT : RD_ISSUE;
            end else begin
               errSet    = refillQ;
               nextState = MISS;
            end
         end
         (state == MISS): begin
            miss_req_o = 1'b1;
            if (miss_done_i) nextState = LOOKUP;
         end
         (state == RD_ISSUE): begin
            arr_re_o  = 1'b1;
            arr_add_o = wordAdd;
            nextState = RD_WAIT;
         end
         (state == RD_WAIT): begin
            loadData  = 1'b1;
            nextState = RD_HOLD;
         end
         (state == RD_HOLD): begin
            if (l1_read_ack_i) begin
               dropValid = 1'b1;
               cntNext   = cnt + CW'(1);
               nextState = (&cnt) ? DONE : RD_ISSUE;
            end
         end
         (state == WR_ACCEPT): begin
            l1_write_ready_o = 1'b1;
            if (l1_write_i) begin
               arr_we_o   = 1'b1;
               arr_add_o  = wordAdd;
               arr_data_o = l1_data_i;
               cntNext    = cnt + CW'(1);
               if (&cnt) nextState = DONE;
            end
         end
         (state == DONE): begin
            l1_done_o = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
      if (l1_read_ack_i && !validQ) errSet = 1'b1;
      if (l1_write_i && !l1_write_ready_o) errSet = 1'b1;
   end

   // state, request latch, read word register and sticky error
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state   <= IDLE;
         cnt     <= '0;
         baseQ   <= '0;
         rwQ     <= RW_READ;
         refillQ <= 1'b0;
         armedQ  <= 1'b0;
         validQ  <= 1'b0;
         dataQ   <= '0;
         errQ    <= 1'b0;
      end else begin
         armedQ <= 1'b1;
         state  <= nextState;
         cnt    <= cntNext;
         if (accept) begin
            baseQ   <= l1_add_i & ~ADDR_W'(BLOCK_WORDS - 1);
            rwQ     <= l1_rw_i;
            refillQ <= 1'b0;
         end else if ((state == MISS) && miss_done_i) begin
            refillQ <= 1'b1;
         end
         if (loadData) begin
            dataQ  <= arr_data_i;
            validQ <= 1'b1;
         end else if (dropValid) begin
            validQ <= 1'b0;
         end
         if (errSet) errQ <= 1'b1;
      end
   end

`ifdef CACHE_L2_RESPONDER_PERF_EN
   logic hitFirst;
   logic missEnter;

   assign hitFirst  = (state == LOOKUP) && arr_hit_i && !refillQ;
   assign missEnter = (state == LOOKUP) && !arr_hit_i;

   l2_perf_counter uHitCnt (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .inc_i   (hitFirst),
      .count_o (perf_hit_o)
   );

   l2_perf_counter uMissCnt (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .inc_i   (missEnter),
      .count_o (perf_miss_o)
   );
`endif

endmodule

// File: tb/tb_cache_l2_l1_responder.sv
// Scoreboard bench for cache_l2_l1_responder: block reads, writes, misses,
// stalls, protocol errors and reset abort.
module tb_cache_l2_l1_responder;
   import l2_link_pkg::*;

   localparam int BW = 4;
   localparam int AW = 24;
   localparam int DW = 32;

   logic          clock_i = 1'b0;
   logic          reset_i = 1'b1;
   logic          l1_req_i = 1'b0;
   logic          l1_rw_i = 1'b0;
   logic [AW-1:0] l1_add_i = '0;
   logic [DW-1:0] l1_data_i = '0;
   logic          l1_write_i = 1'b0;
   logic          l1_read_ack_i = 1'b0;
   logic          l1_ready_o;
   logic          l1_valid_o;
   logic [DW-1:0] l1_data_o;
   logic          l1_write_ready_o;
   logic          l1_done_o;
   logic [AW-1:0] arr_add_o;
   logic          arr_re_o;
   logic          arr_we_o;
   logic [DW-1:0] arr_data_o;
   logic [DW-1:0] arr_data_i = '0;
   logic          arr_hit_i = 1'b1;
   logic          miss_req_o;
   logic          miss_done_i = 1'b0;
   logic          err_o;
`ifdef CACHE_L2_RESPONDER_PERF_EN
   logic [31:0]   perf_hit_o;
   logic [31:0]   perf_miss_o;
`endif

   always #5 clock_i = ~clock_i;

   cache_l2_l1_responder #(
      .BLOCK_WORDS (BW),
      .ADDR_W      (AW),
      .DATA_W      (DW)
   ) dut (
      .clock_i          (clock_i),
      .reset_i          (reset_i),
      .l1_req_i         (l1_req_i),
      .l1_rw_i          (l1_rw_i),
      .l1_add_i         (l1_add_i),
      .l1_data_i        (l1_data_i),
      .l1_write_i       (l1_write_i),
      .l1_read_ack_i    (l1_read_ack_i),
      .l1_ready_o       (l1_ready_o),
      .l1_valid_o       (l1_valid_o),
      .l1_data_o        (l1_data_o),
      .l1_write_ready_o (l1_write_ready_o),
      .l1_done_o        (l1_done_o),
      .arr_add_o        (arr_add_o),
      .arr_re_o         (arr_re_o),
      .arr_we_o         (arr_we_o),
      .arr_data_o       (arr_data_o),
      .arr_data_i       (arr_data_i),
      .arr_hit_i        (arr_hit_i),
      .miss_req_o       (miss_req_o),
      .miss_done_i      (miss_done_i),
      .err_o            (err_o)
`ifdef CACHE_L2_RESPONDER_PERF_EN
      ,
      .perf_hit_o       (perf_hit_o),
      .perf_miss_o      (perf_miss_o)
`endif
   );

   int nChk  = 0;
   int nPass = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      nChk++;
      if (got === exp) nPass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   logic [DW-1:0]    mem [logic [AW-1:0]];
   logic [AW-1:0]    rdAddrQ [$];
   logic [DW-1:0]    rdDataQ [$];
   logic [AW+DW-1:0] wrQ [$];
   int               doneCnt = 0;
   int               missCyc = 0;

   // array model: one-cycle read latency
   always @(posedge clock_i) begin
      if (arr_re_o)
         arr_data_i <= mem.exists(arr_add_o) ? mem[arr_add_o] : 32'hBAD0BAD0;
   end

   // array-side scoreboard and event counters
   always @(negedge clock_i) begin
      if (!reset_i) begin
         if (l1_done_o) doneCnt++;
         if (miss_req_o) missCyc++;
         if (arr_re_o) begin
            if (rdAddrQ.size() == 0) check("re_unexp", arr_re_o, 1'b0);
            else check("re_add", arr_add_o, rdAddrQ.pop_front());
         end
         if (arr_we_o) begin
            if (wrQ.size() == 0) check("we_unexp", arr_we_o, 1'b0);
            else check("we_add_data", {arr_add_o, arr_data_o}, wrQ.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic waitReady();
      int g = 0;
      while (!l1_ready_o && g < 100) begin
         tick();
         g++;
      end
   endtask

   task automatic sendReq(input logic rw, input logic [AW-1:0] add);
      waitReady();
      check("req_ready", l1_ready_o, 1'b1);
      l1_req_i = 1'b1;
      l1_rw_i  = rw;
      l1_add_i = add;
      tick();
      l1_req_i = 1'b0;
   endtask

   task automatic doReset();
      reset_i = 1'b1;
      #1;
      check("rst_ctl", {l1_ready_o, l1_valid_o, l1_write_ready_o, l1_done_o,
                        arr_re_o, arr_we_o, miss_req_o, err_o}, 8'h00);
      check("rst_bus", {arr_add_o, l1_data_o}, '0);
      check("rst_wdata", arr_data_o, '0);
      l1_read_ack_i = 1'b0;
      tick();
      reset_i = 1'b0;
      check("rst_ready_lo", l1_ready_o, 1'b0);
      tick();
      check("rst_ready_hi", l1_ready_o, 1'b1);
   endtask

   task automatic doRead(input logic [AW-1:0] add, input int stallWord,
                         input int stallCyc, input int abortWord);
      logic [AW-1:0] mask;
      logic [AW-1:0] base;
      logic [DW-1:0] held;
      int            d0;
      int            cyc;
      mask = AW'(BW - 1);
      base = add & ~mask;
      for (int i = 0; i < BW; i++) begin
         rdAddrQ.push_back(base | AW'(i));
         rdDataQ.push_back(mem[base | AW'(i)]);
      end
      d0 = doneCnt;
      arr_hit_i = 1'b1;
      sendReq(RW_READ, add);
      cyc = 1;
      for (int w = 0; w < BW; w++) begin
         while (!l1_valid_o && cyc < 100) begin
            tick();
            cyc++;
         end
         if (w == 0) check("rd_latency", cyc, 4);
         check("rd_valid", l1_valid_o, 1'b1);
         check("rd_data", l1_data_o, rdDataQ.pop_front());
         if (w == abortWord) begin
            doReset();
            rdAddrQ.delete();
            rdDataQ.delete();
            tick();
            tick();
            check("abort_no_done", doneCnt, d0);
            return;
         end
         if (w == stallWord) begin
            held = l1_data_o;
            repeat (stallCyc) begin
               tick();
               check("stall_valid", l1_valid_o, 1'b1);
               check("stall_data", l1_data_o, held);
            end
         end
         tick();
         l1_read_ack_i = 1'b1;
         tick();
         l1_read_ack_i = 1'b0;
         check("rd_drop", l1_valid_o, 1'b0);
         cyc = 0;
      end
      waitReady();
      check("rd_done_once", doneCnt - d0, 1);
      check("rd_q_empty", rdAddrQ.size(), 0);
   endtask

   task automatic doWrite(input logic [AW-1:0] add, input int missDelay,
                          input logic [DW-1:0] seed);
      logic [AW-1:0] mask;
      logic [AW-1:0] base;
      int            d0;
      int            m0;
      int            g;
      mask = AW'(BW - 1);
      base = add & ~mask;
      for (int i = 0; i < BW; i++)
         wrQ.push_back({base | AW'(i), seed + DW'(i)});
      d0 = doneCnt;
      m0 = missCyc;
      arr_hit_i = (missDelay == 0);
      sendReq(RW_WRITE, add);
      if (missDelay > 0) begin
         g = 0;
         while (!miss_req_o && g < 100) begin
            tick();
            g++;
         end
         check("miss_req", miss_req_o, 1'b1);
         repeat (missDelay - 1) tick();
         miss_done_i = 1'b1;
         arr_hit_i   = 1'b1;
         tick();
         miss_done_i = 1'b0;
      end
      g = 0;
      while (!l1_write_ready_o && g < 100) begin
         tick();
         g++;
      end
      check("wr_ready", l1_write_ready_o, 1'b1);
      for (int i = 0; i < BW; i++) begin
         l1_write_i = 1'b1;
         l1_data_i  = seed + DW'(i);
         tick();
      end
      l1_write_i = 1'b0;
      waitReady();
      check("wr_done_once", doneCnt - d0, 1);
      check("wr_q_empty", wrQ.size(), 0);
      if (missDelay > 0) check("miss_cycles", missCyc - m0, missDelay);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < BW; i++) begin
         mem[24'h000010 + AW'(i)] = 32'hA0 + DW'(i);
         mem[24'h000040 + AW'(i)] = 32'hC0DE_0040 + DW'(i);
         mem[24'h000080 + AW'(i)] = 32'h5EED_0080 + DW'(i);
      end
      tick();
      check("reset_ctl", {l1_ready_o, l1_valid_o, l1_write_ready_o, l1_done_o,
                          arr_re_o, arr_we_o, miss_req_o, err_o}, 8'h00);
      tick();
      reset_i = 1'b0;
      check("ready_before_clk", l1_ready_o, 1'b0);
      tick();
      check("ready_after_clk", l1_ready_o, 1'b1);

      doRead(24'h000013, -1, 0, -1);
      doWrite(24'h000200, 20, 32'hD000_0000);
      doRead(24'h000041, 2, 10, -1);

      check("err_clear", err_o, 1'b0);
      l1_read_ack_i = 1'b1;
      tick();
      l1_read_ack_i = 1'b0;
      tick();
      check("err_set", err_o, 1'b1);
      doRead(24'h000080, -1, 0, -1);
      check("err_sticky", err_o, 1'b1);

      doRead(24'h000082, -1, 0, 1);

      doRead(24'h000010, -1, 0, -1);
      doWrite(24'h000300, 0, 32'hE000_0000);
      doRead(24'h000040, -1, 0, -1);
      doWrite(24'h000400, 5, 32'hF000_0000);
      doWrite(24'h000503, 3, 32'h1234_0000);
`ifdef CACHE_L2_RESPONDER_PERF_EN
      check("perf_hit", perf_hit_o, 32'd3);
      check("perf_miss", perf_miss_o, 32'd2);
`endif
      check("err_after_rst", err_o, 1'b0);

      $display("%0d/%0d checks passed", nPass, nChk);
      $finish;
   end

endmodule
